// File: rtl/matmul_result_drain_if.sv
// rtl/matmul_result_drain_if.sv - start/capture and result-stream bundle for matmul_result_drain
interface matmul_result_drain_if #(
  parameter int BUS_WIDTH = 64,
  parameter int N = 4,
  parameter int M = 1
);
  localparam int NM = N * M;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  logic                    start_i;
  logic [NM*BUS_WIDTH-1:0] c_flat_i;
  logic                    busy_o;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [BUS_WIDTH-1:0]    out_data_o;
  logic [RW-1:0]           out_row_o;
  logic [CW-1:0]           out_col_o;
  logic                    out_last_o;
  logic                    done_o;
  logic                    ovf_o;

  // Drain side: takes the matrix and the consumer ready, produces the stream.
  modport slave (
    input  start_i, c_flat_i, out_ready_i,
    output busy_o, out_valid_o, out_data_o, out_row_o, out_col_o, out_last_o, done_o, ovf_o
  );

  // Environment side: calculation core plus result consumer.
  modport master (
    output start_i, c_flat_i, out_ready_i,
    input  busy_o, out_valid_o, out_data_o, out_row_o, out_col_o, out_last_o, done_o, ovf_o
  );
endinterface

// File: rtl/matmul_result_drain.sv
// rtl/matmul_result_drain.sv - captures result matrix C and streams it row-major; optional MATMUL_DRAIN_SAT_EN clamping
module matmul_result_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int N          = 4,
  parameter int M          = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  matmul_result_drain_if.slave drain
);
  localparam int NM = N * M;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [IW-1:0] IdxLast = IW'(NM - 1);
  localparam logic [CW-1:0] ColLast = CW'(M - 1);

  if (DATA_WIDTH < 2 || DATA_WIDTH > BUS_WIDTH) begin : gBadConfig
    $error("matmul_result_drain: DATA_WIDTH must lie in 2..BUS_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SEND, DONE} stateT;

  stateT                state;
  stateT                stateNext;
  logic                 startAcc;
  logic                 xfer;
  logic                 inSend;
  logic                 inDone;
  logic [IW-1:0]        idx;
  logic [RW-1:0]        rowCnt;
  logic [CW-1:0]        colCnt;
  logic [BUS_WIDTH-1:0] buffer [NM];
  logic [BUS_WIDTH-1:0] rawElem;
  logic [BUS_WIDTH-1:0] elemOut;

  // State register; reset abandons any partial stream without a done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and handshake decode; start is only honoured from IDLE.
  always_comb begin
    stateNext = state;
    startAcc  = 1'b0;
    xfer      = 1'b0;
    inSend    = 1'b0;
    inDone    = 1'b0;
    case (state)
      IDLE: begin
        if (drain.start_i) begin
          startAcc  = 1'b1;
          stateNext = SEND;
        end
      end
      SEND: begin
        inSend = 1'b1;
        xfer   = drain.out_ready_i;
        if (xfer && idx == IdxLast) stateNext = DONE;
      end
      DONE: begin
        inDone    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Snapshot of C so the core is free to start its next operation.
  always_ff @(posedge clk_i) begin
    if (startAcc) begin
      for (int e = 0; e < NM; e++) buffer[e] <= drain.c_flat_i[e*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  // Beat index plus row/column counters stepped together, avoiding a divider.
  always_ff @(posedge clk_i) begin
    if (rst_i || startAcc) begin
      idx    <= '0;
      rowCnt <= '0;
      colCnt <= '0;
    end else if (xfer && idx != IdxLast) begin
      idx <= idx + 1'b1;
      if (colCnt == ColLast) begin
        colCnt <= '0;
        rowCnt <= rowCnt + 1'b1;
      end else begin
        colCnt <= colCnt + 1'b1;
      end
    end
  end

  assign rawElem = buffer[idx];

`ifdef MATMUL_DRAIN_SAT_EN
  localparam logic signed [BUS_WIDTH-1:0] SatMax =
    {{(BUS_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [BUS_WIDTH-1:0] SatMin =
    {{(BUS_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic clamped;
  logic ovfReg;

  // Clamp the current element into the signed DATA_WIDTH range, sign-extended.
  always_comb begin
    elemOut = rawElem;
    clamped = 1'b0;
    if ($signed(rawElem) > SatMax) begin
      elemOut = SatMax;
      clamped = 1'b1;
    end else if ($signed(rawElem) < SatMin) begin
      elemOut = SatMin;
      clamped = 1'b1;
    end
  end

  // Sticky overflow: set by a transferred clamped beat, cleared by a new matrix.
  always_ff @(posedge clk_i) begin
    if (rst_i || startAcc)  ovfReg <= 1'b0;
    else if (xfer && clamped) ovfReg <= 1'b1;
  end

  assign drain.ovf_o = ovfReg;
`else
  assign elemOut     = rawElem;
  assign drain.ovf_o = 1'b0;
`endif

  assign drain.busy_o      = inSend | inDone;
  assign drain.out_valid_o = inSend;
  assign drain.done_o      = inDone;
  assign drain.out_data_o  = inSend ? elemOut : '0;
  assign drain.out_row_o   = inSend ? rowCnt : '0;
  assign drain.out_col_o   = inSend ? colCnt : '0;
  assign drain.out_last_o  = inSend && (idx == IdxLast);
endmodule

// File: doc/matmul_result_drain.md
# matmul_result_drain

Downstream stage of the matmul calculator: on a start pulse, captures the full result matrix C (N×M elements, each BUS_WIDTH bits wide) and streams it out one element per beat, row-major, over a valid/ready interface. Each beat carries row/column indices and a last flag. It decouples the calculation core, which can begin its next operation immediately, from a slower result consumer such as the bus-side result memory writer.

## Interface
- DATA_WIDTH, 32, operand element width; used only by the saturation feature.
- BUS_WIDTH, 64, result element width and output data width.
- N, 4, rows of C.
- M, 1, columns of C.
- Derived: NM = N*M; RW = max(1, $clog2(N)); CW = max(1, $clog2(M)); IW = max(1, $clog2(NM)).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- start_i  in  1  one-cycle pulse; c_flat_i is valid in this cycle.
- c_flat_i  in  NM*BUS_WIDTH  element (i,j) at bits [(i*M+j)*BUS_WIDTH +: BUS_WIDTH].
- busy_o  out  1  high from the cycle after an accepted start until done_o completes.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  consumer ready.
- out_data_o  out  BUS_WIDTH  element value; 0 when out_valid_o is low.
- out_row_o  out  RW  row index i of the current beat.
- out_col_o  out  CW  column index j of the current beat.
- out_last_o  out  1  high on the beat for element (N-1, M-1).
- done_o  out  1  one-cycle pulse after the last beat is accepted.
- ovf_o  out  1  sticky saturation flag; constant 0 unless the saturation feature is compiled in.

## Operation
- Internal state: buffer of NM×BUS_WIDTH registers; beat index idx (IW bits); FSM with states IDLE, SEND and DONE.
- IDLE:
  - Outputs: busy_o=0, out_valid_o=0.
  - start_i=1 captures all of c_flat_i into the buffer, sets idx=0, and moves to SEND.
- SEND:
  - Outputs: busy_o=1, out_valid_o=1, out_data_o=buffer[idx], out_row_o=idx/M, out_col_o=idx%M, out_last_o=(idx==NM-1).
  - Handshake: a beat transfers when out_valid_o and out_ready_i are both high in the same cycle.
  - On a transfer: if idx==NM-1, move to DONE; otherwise idx increments.
  - With no transfer, all out_* outputs hold stable.
  - Row and column indices are derived from a row/column counter pair, not a divider.
- DONE:
  - Outputs: done_o=1, busy_o=1, out_valid_o=0.
  - Next cycle: return to IDLE.
- start_i in SEND or DONE is ignored; the buffer is not overwritten and no error is raised.
- No beat is skipped or repeated. The order is (0,0), (0,1), …, (N-1,M-1).

## Timing
- Reset values: busy_o=0, out_valid_o=0, out_data_o=0, out_row_o=0, out_col_o=0, out_last_o=0, done_o=0, ovf_o=0; FSM=IDLE; idx=0.
- Start latency: start_i high at edge t puts the first beat on out_valid_o after edge t, i.e. visible in cycle t+1.
- Throughput: with out_ready_i held high, one beat per cycle. NM beats occupy cycles t+1..t+NM; done_o is high in cycle t+NM+1.
- The earliest accepted next start_i is in cycle t+NM+2 (IDLE).
- Reset asserted in any state returns to IDLE on the next edge. A partial transfer is abandoned; no done_o is produced.
- Back-pressure: out_ready_i may toggle arbitrarily. out_valid_o never drops in SEND before the last transfer.
- out_ready_i is ignored outside SEND.

## Configuration
- Macro: MATMUL_DRAIN_SAT_EN.
- Defined:
  - Each buffer element is treated as signed BUS_WIDTH.
  - Values above 2^(DATA_WIDTH-1)-1 clamp to that value; values below -2^(DATA_WIDTH-1) clamp to that value.
  - The result is sign-extended to BUS_WIDTH on out_data_o.
  - ovf_o sets on the first transferred beat that was clamped and stays high until reset or the next accepted start_i.
- Undefined:
  - out_data_o is the raw element.
  - ovf_o is tied to 0.
  - No saturation logic is generated.

## Test plan
- Basic stream: N=4, M=1, elements 10, 20, 30, 40; start_i at cycle 5 with out_ready_i=1.
  - Required: beats 10, 20, 30, 40 in cycles 6–9, rows 0–3, out_last_o in cycle 9.
  - Required: done_o in cycle 10; busy_o high in cycles 6–10.
- Back-pressure: same data, out_ready_i toggling 1,0,0,1,0,1,…
  - Required: each value is held stable until transferred; exactly 4 transfers, in order; done_o one cycle after the 4th transfer.
- Ignored start: a second start_i with new data during SEND.
  - Required: the original data is still streamed; the new data never appears.
- Reset mid-stream: rst_i high for one cycle after 2 beats are transferred.
  - Required: next cycle out_valid_o=0, busy_o=0, and done_o is never pulsed; a following start streams from element (0,0).
- 2×2 indexing: N=2, M=2, elements 1, 2, 3, 4.
  - Required: (row, col) sequence (0,0), (0,1), (1,0), (1,1); out_last_o only on value 4.
- Saturation (macro defined, DATA_WIDTH=32): elements 0x0000_0001_0000_0000, -5, 0xFFFF_FFFF_0000_0000 (-2^32), 7.
  - Required: outputs 0x0000_0000_7FFF_FFFF, -5, 0xFFFF_FFFF_8000_0000, 7.
  - Required: ovf_o rises after the first beat and clears on the next start.
